// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, digit type and preset clamping for countdown_timer.
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } tmr_state_t;

  localparam int DIV_CNT_50M = 500000;

  typedef logic [3:0] bcd_t;

  // Out-of-range preset digits saturate to the largest legal digit for that position.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    bcd_t tens;
    bcd_t ones;
    tens = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, ones};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dec_digit.sv
// bcd_dec_digit: one BCD digit of a borrow-chained decrementer (combinational).
`default_nettype none

module bcd_dec_digit
  import timer_pkg::*;
(
  input  bcd_t i_digit,
  input  bcd_t i_max,
  input  logic i_borrow,
  output bcd_t o_digit,
  output logic o_borrow
);

  logic w_is_zero;

  assign w_is_zero = (i_digit == 4'd0);

  always_comb begin
    o_digit = i_digit;
    if (i_borrow) begin
      o_digit = w_is_zero ? i_max : (i_digit - 4'd1);
    end
  end

  assign o_borrow = i_borrow & w_is_zero;

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS.hh BCD countdown with internal 1/100 s divider and alarm pulse.
// Optional AUTO_RELOAD_EN: re-arm from the last loaded preset on expiry instead of stopping.
`default_nettype none

module countdown_timer
  import timer_pkg::*;
#(
  parameter int DIV_CNT = DIV_CNT_50M,
  parameter int DIV_W   = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] hund_bcd,
  output logic       running,
  output logic       expired,
  output logic       alarm
);

  localparam logic [DIV_W-1:0] C_DIV_RELOAD = DIV_W'(DIV_CNT - 1);

  tmr_state_t       r_state;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_min;
  logic [7:0]       r_sec;
  logic [7:0]       r_hund;
  logic             r_alarm;
  logic             r_expired;

  bcd_t       w_digit [6];
  bcd_t       w_next  [6];
  logic [6:0] w_borrow;
  logic       w_tick;
  logic       w_time_zero;
  logic       w_last_hund;
  logic [7:0] w_load_min;
  logic [7:0] w_load_sec;

  // Digit order is least significant first so the borrow ripples upward.
  assign w_digit[0] = r_hund[3:0];
  assign w_digit[1] = r_hund[7:4];
  assign w_digit[2] = r_sec[3:0];
  assign w_digit[3] = r_sec[7:4];
  assign w_digit[4] = r_min[3:0];
  assign w_digit[5] = r_min[7:4];
  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      localparam bcd_t C_MAX = ((gi == 3) || (gi == 5)) ? 4'd5 : 4'd9;
      bcd_dec_digit u_digit (
        .i_digit  (w_digit[gi]),
        .i_max    (C_MAX),
        .i_borrow (w_borrow[gi]),
        .o_digit  (w_next[gi]),
        .o_borrow (w_borrow[gi+1])
      );
    end
  endgenerate

  // A borrow out of the top digit means every digit was already zero.
  assign w_time_zero = w_borrow[6];
  assign w_last_hund = ({r_min, r_sec, r_hund} == 24'h00_00_01);
  assign w_tick      = (r_div == '0);
  assign w_load_min  = clamp_bcd(preset_min);
  assign w_load_sec  = clamp_bcd(preset_sec);

`ifdef AUTO_RELOAD_EN
  logic [7:0] r_shadow_min;
  logic [7:0] r_shadow_sec;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_min <= 8'h00;
      r_shadow_sec <= 8'h00;
    end else if (!clear && load && (r_state != RUN)) begin
      r_shadow_min <= w_load_min;
      r_shadow_sec <= w_load_sec;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div     <= C_DIV_RELOAD;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_hund    <= 8'h00;
      r_alarm   <= 1'b0;
      r_expired <= 1'b0;
    end else if (clear) begin
      r_state   <= IDLE;
      r_div     <= C_DIV_RELOAD;
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_hund    <= 8'h00;
      r_alarm   <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_alarm <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_expired <= 1'b0;
`endif
      unique case (r_state)
        IDLE, PAUSE: begin
          if (load) begin
            r_min  <= w_load_min;
            r_sec  <= w_load_sec;
            r_hund <= 8'h00;
          end else if (start && !w_time_zero) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          // The divider holds on pause so the partial period survives a resume.
          if (pause) begin
            r_state <= PAUSE;
          end else if (w_tick) begin
            r_div <= C_DIV_RELOAD;
            if (w_last_hund || w_time_zero) begin
              r_alarm   <= 1'b1;
              r_expired <= 1'b1;
`ifdef AUTO_RELOAD_EN
              r_min  <= r_shadow_min;
              r_sec  <= r_shadow_sec;
              r_hund <= 8'h00;
`else
              r_min   <= 8'h00;
              r_sec   <= 8'h00;
              r_hund  <= 8'h00;
              r_state <= EXPIRED;
`endif
            end else begin
              r_hund <= {w_next[1], w_next[0]};
              r_sec  <= {w_next[3], w_next[2]};
              r_min  <= {w_next[5], w_next[4]};
            end
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        EXPIRED: begin
          if (load) begin
            r_min     <= w_load_min;
            r_sec     <= w_load_sec;
            r_hund    <= 8'h00;
            r_state   <= IDLE;
            r_expired <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign min_bcd  = r_min;
  assign sec_bcd  = r_sec;
  assign hund_bcd = r_hund;
  assign running  = (r_state == RUN);
  assign expired  = r_expired;
  assign alarm    = r_alarm;

endmodule

`default_nettype wire
